pll_phase_stepper: RTL and testbench
====================================

PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

Interface
REQ-001 SHALL have parameter PHASE_EN_CYC, default 2: cycles phase_en is held high per step.
REQ-002 SHALL have parameter DONE_TO, default 255: max cycles waiting for phase_done per step.
REQ-003 SHALL have parameter LOCK_SETTLE, default 16: consecutive pll_locked-high cycles required after the last step.
REQ-004 SHALL have parameter LOCK_TO, default 4095: max cycles in WAIT_LOCK.
REQ-005 SHALL have port clk_clk, input, 1: sole clock, all logic rising-edge.
REQ-006 SHALL have port reset_reset_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port cmd_valid, input, 1: command present (from Nios-V PIO).
REQ-008 SHALL have port cmd_ready, output, 1: block can accept a command.
REQ-009 SHALL have port cmd_steps, input, 16: unsigned step count.
REQ-010 SHALL have port cmd_dir, input, 1: 1 = phase up, 0 = phase down.
REQ-011 SHALL have port cmd_cntsel, input, 5: PLL counter select (theta/phi output).
REQ-012 SHALL have port pos_clear, input, 1: clear the position accumulator.
REQ-013 SHALL have port pll_locked, input, 1: PLL lock indicator.
REQ-014 SHALL have port phase_done, input, 1: PLL step-complete, active-high.
REQ-015 SHALL have port phase_en, output, 1: PLL dynamic phase-shift enable.
REQ-016 SHALL have port updn, output, 1: direction to PLL.
REQ-017 SHALL have port cntsel, output, 5: counter select to PLL.
REQ-018 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-019 SHALL have port status, output, 32: [31:30] err, [29:27] state, [26] pll_locked, [25:16] zero, [15:0] position; feeds the locked_*_in PIO.

Function
REQ-020 SHALL implement states IDLE(0), ASSERT_EN(1), WAIT_DONE(2), GAP(3), WAIT_LOCK(4), FINISH(5).
REQ-021 SHALL drive cmd_ready=1 only in IDLE; accept on cmd_valid&&cmd_ready, latching steps, dir, cntsel and clearing err.
REQ-022 On accept with pll_locked=0, SHALL set err=01, go FINISH, and issue no phase_en.
REQ-023 On accept with cmd_steps=0 and pll_locked=1, SHALL go FINISH directly (err=00, no phase_en).
REQ-024 Otherwise SHALL enter ASSERT_EN the cycle after accept.
REQ-025 SHALL hold phase_en high for exactly PHASE_EN_CYC cycles in ASSERT_EN, then enter WAIT_DONE with phase_en low.
REQ-026 SHALL keep updn and cntsel equal to the latched values from accept until return to IDLE.
REQ-027 In WAIT_DONE, on phase_done=1 SHALL decrement remaining steps and add +1 (dir=1) or -1 (dir=0) to position, 16-bit two's complement wrap (0x7FFF+1 -> 0x8000, 0x0000-1 -> 0xFFFF).
REQ-028 SHALL go to GAP (1 cycle) after phase_done if remaining>0 and then to ASSERT_EN; if remaining=0, SHALL go to WAIT_LOCK.
REQ-029 SHALL, if WAIT_DONE lasts DONE_TO cycles without phase_done, set err=10 and go FINISH; position unchanged for that step.
REQ-030 In WAIT_LOCK SHALL count consecutive pll_locked=1 cycles (restart on any 0); on reaching LOCK_SETTLE go FINISH with err=00.
REQ-031 SHALL set err=11 and go FINISH if WAIT_LOCK lasts LOCK_TO cycles without settling.
REQ-032 SHALL pulse done=1 for exactly one cycle in FINISH, then return to IDLE.
REQ-033 SHALL clear position on pos_clear only in IDLE; pos_clear elsewhere ignored.
REQ-034 SHALL hold err until the next accepted command.
REQ-035 status SHALL be registered, reflecting state, err and position one cycle after they change; bit 26 samples pll_locked.

Reset
REQ-036 With reset_reset_n=0 at a clock edge, SHALL enter IDLE, with phase_en=0, updn=0, cntsel=0, done=0, err=00, position=0, status=0, cmd_ready=0 during reset and 1 the first cycle after release.
REQ-037 Reset mid-sequence SHALL deassert phase_en at that edge and discard remaining steps; no done pulse.

Verification
REQ-038 Locked PLL, cmd steps=3 dir=1 cntsel=2, phase_done 4 cycles after each phase_en fall -> three 2-cycle phase_en pulses, position=3, done once, err=00.
REQ-039 pll_locked=0 at accept -> no phase_en, done one cycle later, status[31:30]=01.
REQ-040 steps=1, phase_done never asserted -> done after 255 WAIT_DONE cycles, err=10, position unchanged.
REQ-041 position=0, steps=2 dir=0 -> position=0xFFFE; then pos_clear in IDLE -> 0x0000.
REQ-042 pll_locked toggles low at 10th settle cycle -> counter restarts, FINISH 16 cycles after relock; reset asserted in ASSERT_EN -> phase_en=0 next cycle, status=0.

Source files
------------

// File: rtl/pll_phase_stepper.sv
// Dynamic phase-shift sequencer for a PLL: takes a step command, issues
// phase_en pulses one step at a time, waits for each phase_done handshake,
// then waits for the PLL to report a settled lock before signalling done.
// A signed position accumulator tracks the net number of steps taken.
module pll_phase_stepper #(
    parameter int PHASE_EN_CYC = 2,
    parameter int DONE_TO      = 255,
    parameter int LOCK_SETTLE  = 16,
    parameter int LOCK_TO      = 4095
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_steps,
    input  logic        cmd_dir,
    input  logic [4:0]  cmd_cntsel,
    input  logic        pos_clear,
    input  logic        pll_locked,
    input  logic        phase_done,
    output logic        phase_en,
    output logic        updn,
    output logic [4:0]  cntsel,
    output logic        done,
    output logic [31:0] status
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ASSERT_EN = 3'd1,
        WAIT_DONE = 3'd2,
        GAP       = 3'd3,
        WAIT_LOCK = 3'd4,
        FINISH    = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNLOCKED = 2'b01;
    localparam logic [1:0] ERR_DONE_TO  = 2'b10;
    localparam logic [1:0] ERR_LOCK_TO  = 2'b11;

    // Counter widths sized to hold 0 .. N-1 for each timed phase.
    localparam int EN_W = (PHASE_EN_CYC > 1) ? $clog2(PHASE_EN_CYC) : 1;
    localparam int DT_W = (DONE_TO > 1)      ? $clog2(DONE_TO)      : 1;
    localparam int LS_W = (LOCK_SETTLE > 1)  ? $clog2(LOCK_SETTLE)  : 1;
    localparam int LT_W = (LOCK_TO > 1)      ? $clog2(LOCK_TO)      : 1;

    localparam logic [EN_W-1:0] EN_LAST = EN_W'(PHASE_EN_CYC - 1);
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DONE_TO - 1);
    localparam logic [LS_W-1:0] LS_LAST = LS_W'(LOCK_SETTLE - 1);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(LOCK_TO - 1);

    state_t             state;
    logic [1:0]         err;
    logic signed [15:0] position;
    logic [15:0]        remaining;
    logic [EN_W-1:0]    en_cnt;
    logic [DT_W-1:0]    wait_cnt;
    logic [LS_W-1:0]    settle_cnt;
    logic [LT_W-1:0]    lock_cnt;

    // One step up or down with natural 16-bit two's complement wrap.
    function automatic logic signed [15:0] step_position(
        input logic signed [15:0] pos,
        input logic               up
    );
        return up ? (pos + 16'sd1) : (pos - 16'sd1);
    endfunction

    // Sequencer FSM: command handshake, phase_en pulses, handshake/lock timeouts, position tracking
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            phase_en   <= 1'b0;
            updn       <= 1'b0;
            cntsel     <= 5'd0;
            done       <= 1'b0;
            err        <= ERR_NONE;
            position   <= '0;
            remaining  <= '0;
            en_cnt     <= '0;
            wait_cnt   <= '0;
            settle_cnt <= '0;
            lock_cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (pos_clear) begin
                        position <= '0;
                    end
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        remaining <= cmd_steps;
                        updn      <= cmd_dir;
                        cntsel    <= cmd_cntsel;
                        err       <= ERR_NONE;
                        if (!pll_locked) begin
                            // Never shift phase on an unlocked PLL.
                            err   <= ERR_UNLOCKED;
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (cmd_steps == 16'd0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state    <= ASSERT_EN;
                            phase_en <= 1'b1;
                            en_cnt   <= '0;
                        end
                    end
                end

                ASSERT_EN: begin
                    if (en_cnt == EN_LAST) begin
                        phase_en <= 1'b0;
                        wait_cnt <= '0;
                        state    <= WAIT_DONE;
                    end else begin
                        en_cnt <= en_cnt + EN_W'(1);
                    end
                end

                WAIT_DONE: begin
                    if (phase_done) begin
                        remaining <= remaining - 16'd1;
                        position  <= step_position(position, updn);
                        if (remaining == 16'd1) begin
                            settle_cnt <= '0;
                            lock_cnt   <= '0;
                            state      <= WAIT_LOCK;
                        end else begin
                            state <= GAP;
                        end
                    end else if (wait_cnt == DT_LAST) begin
                        // Step abandoned: position is not updated for it.
                        err   <= ERR_DONE_TO;
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + DT_W'(1);
                    end
                end

                GAP: begin
                    // One idle cycle between consecutive phase_en pulses.
                    phase_en <= 1'b1;
                    en_cnt   <= '0;
                    state    <= ASSERT_EN;
                end

                WAIT_LOCK: begin
                    if (pll_locked && (settle_cnt == LS_LAST)) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else if (lock_cnt == LT_LAST) begin
                        err   <= ERR_LOCK_TO;
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        lock_cnt   <= lock_cnt + LT_W'(1);
                        // Settling requires an unbroken run of lock cycles.
                        settle_cnt <= pll_locked ? (settle_cnt + LS_W'(1)) : '0;
                    end
                end

                FINISH: begin
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    phase_en <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Status word: registered snapshot of err, state, lock input and position
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            status <= '0;
        end else begin
            status <= {err, state, pll_locked, 10'd0, position};
        end
    end

endmodule

// File: tb/tb_pll_phase_stepper.sv
// Directed bench for pll_phase_stepper: a table of step commands with
// hand-computed latency/err/position, plus hand-written sequences for
// position clear, lock glitch, lock timeout and mid-sequence reset.
module tb_pll_phase_stepper;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_steps = 16'd0;
    logic        cmd_dir = 1'b0;
    logic [4:0]  cmd_cntsel = 5'd0;
    logic        pos_clear = 1'b0;
    logic        pll_locked = 1'b1;
    logic        phase_done = 1'b0;
    logic        phase_en;
    logic        updn;
    logic [4:0]  cntsel;
    logic        done;
    logic [31:0] status;

    int tests = 0;
    int failed = 0;

    pll_phase_stepper dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_steps     (cmd_steps),
        .cmd_dir       (cmd_dir),
        .cmd_cntsel    (cmd_cntsel),
        .pos_clear     (pos_clear),
        .pll_locked    (pll_locked),
        .phase_done    (phase_done),
        .phase_en      (phase_en),
        .updn          (updn),
        .cntsel        (cntsel),
        .done          (done),
        .status        (status)
    );

    always #5 clk_clk = ~clk_clk;

    // PLL responder (phase_done sampled on the 4th edge after phase_en falls)
    // and pulse monitor, both on the falling edge.
    logic resp_on = 1'b1;
    logic prev_en = 1'b0;
    int   resp_cnt = 0;
    int   rises = 0;
    int   en_cycles = 0;
    int   done_pulses = 0;

    always @(negedge clk_clk) begin
        if (phase_en && !prev_en) rises++;
        if (phase_en) en_cycles++;
        if (done) done_pulses++;
        if (!resp_on) begin
            resp_cnt   = 0;
            phase_done = 1'b0;
        end else begin
            if (prev_en && !phase_en) resp_cnt = 4;
            else if (resp_cnt > 0) resp_cnt--;
            phase_done = (resp_cnt == 1);
        end
        prev_en = phase_en;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic accept(input logic [15:0] s, input logic d, input logic [4:0] c,
                          output logic en_first);
        cmd_steps  = s;
        cmd_dir    = d;
        cmd_cntsel = c;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid = 1'b0;
        en_first  = phase_en;
        check("ready_low_after_accept", {31'd0, cmd_ready}, 32'd0);
    endtask

    // Edges after the accept edge until done is seen (0 = done right after accept).
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 6000) begin
            tick();
            lat++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] steps;
        logic        dir;
        logic [4:0]  csel;
        logic        locked;
        logic        resp;
        int          lat;
        logic [1:0]  err;
        int          pulses;
        logic [15:0] pos;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs[NV];

    int   lat;
    logic en_first;
    int   r0, e0, d0;

    initial begin
        // Latency per stepped command: 7*steps - 1 step edges + 16 settle edges.
        vecs[0] = '{16'd3, 1'b1, 5'd2,  1'b1, 1'b1, 36,  2'b00, 3, 16'h0003};
        vecs[1] = '{16'd0, 1'b0, 5'd7,  1'b1, 1'b1, 0,   2'b00, 0, 16'h0003};
        vecs[2] = '{16'd2, 1'b0, 5'd31, 1'b0, 1'b1, 0,   2'b01, 0, 16'h0003};
        vecs[3] = '{16'd5, 1'b0, 5'd1,  1'b1, 1'b1, 50,  2'b00, 5, 16'hFFFE};
        vecs[4] = '{16'd1, 1'b1, 5'd0,  1'b1, 1'b1, 22,  2'b00, 1, 16'hFFFF};
        vecs[5] = '{16'd1, 1'b1, 5'd9,  1'b1, 1'b0, 257, 2'b10, 1, 16'hFFFF};
        vecs[6] = '{16'd2, 1'b1, 5'd20, 1'b1, 1'b1, 29,  2'b00, 2, 16'h0001};

        // Reset state
        repeat (3) tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rst_phase_en", {31'd0, phase_en}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_status", status, 32'd0);
        check("rst_updn_cntsel", {26'd0, updn, cntsel}, 32'd0);
        reset_reset_n = 1'b1;
        tick();
        check("release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("release_status", status, 32'h0400_0000);

        // Command table
        for (int i = 0; i < NV; i++) begin
            pll_locked = vecs[i].locked;
            resp_on    = vecs[i].resp;
            r0 = rises;
            e0 = en_cycles;
            d0 = done_pulses;
            accept(vecs[i].steps, vecs[i].dir, vecs[i].csel, en_first);
            check($sformatf("v%0d_en_first", i), {31'd0, en_first},
                  {31'd0, (vecs[i].steps != 16'd0) && vecs[i].locked});
            wait_done(lat);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            tick();
            check($sformatf("v%0d_done_one_cycle", i), {31'd0, done}, 32'd0);
            check($sformatf("v%0d_err", i), {30'd0, status[31:30]}, {30'd0, vecs[i].err});
            check($sformatf("v%0d_state_finish", i), {29'd0, status[29:27]}, 32'd5);
            check($sformatf("v%0d_locked_bit", i), {31'd0, status[26]}, {31'd0, vecs[i].locked});
            check($sformatf("v%0d_position", i), {16'd0, status[15:0]}, {16'd0, vecs[i].pos});
            check($sformatf("v%0d_pulses", i), rises - r0, vecs[i].pulses);
            check($sformatf("v%0d_en_cycles", i), en_cycles - e0, 2 * vecs[i].pulses);
            check($sformatf("v%0d_done_count", i), done_pulses - d0, 1);
            check($sformatf("v%0d_updn_cntsel", i), {26'd0, updn, cntsel},
                  {26'd0, vecs[i].dir, vecs[i].csel});
            tick();
            check($sformatf("v%0d_state_idle", i), {29'd0, status[29:27]}, 32'd0);
            check($sformatf("v%0d_err_held", i), {30'd0, status[31:30]}, {30'd0, vecs[i].err});
        end
        pll_locked = 1'b1;
        resp_on    = 1'b1;

        // pos_clear in IDLE, with status lagging one cycle
        pos_clear = 1'b1;
        tick();
        pos_clear = 1'b0;
        check("clear_status_lag", {16'd0, status[15:0]}, 32'h0001);
        tick();
        check("clear_position", {16'd0, status[15:0]}, 32'h0000);

        // Two down-steps from zero; pos_clear held during the run is ignored
        accept(16'd2, 1'b0, 5'd3, en_first);
        pos_clear = 1'b1;
        wait_done(lat);
        pos_clear = 1'b0;
        check("down2_latency", lat, 29);
        tick();
        check("down2_position", {16'd0, status[15:0]}, 32'hFFFE);
        tick();

        // Lock drops on the 10th settle edge: settle count restarts
        accept(16'd1, 1'b1, 5'd6, en_first);
        repeat (15) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        repeat (15) tick();
        check("relock_not_early", {31'd0, done}, 32'd0);
        tick();
        check("relock_done", {31'd0, done}, 32'd1);
        tick();
        check("relock_err", {30'd0, status[31:30]}, 32'd0);
        check("relock_position", {16'd0, status[15:0]}, 32'hFFFF);
        tick();

        // Reset while phase_en is high
        accept(16'd3, 1'b1, 5'd2, en_first);
        check("rstmid_en_first", {31'd0, en_first}, 32'd1);
        tick();
        check("rstmid_en_second", {31'd0, phase_en}, 32'd1);
        reset_reset_n = 1'b0;
        tick();
        check("rstmid_phase_en", {31'd0, phase_en}, 32'd0);
        check("rstmid_status", status, 32'd0);
        check("rstmid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        check("rstmid_done", {31'd0, done}, 32'd0);
        check("rstmid_updn_cntsel", {26'd0, updn, cntsel}, 32'd0);
        reset_reset_n = 1'b1;
        r0 = rises;
        d0 = done_pulses;
        tick();
        check("rstmid_ready_after", {31'd0, cmd_ready}, 32'd1);
        check("rstmid_position", {16'd0, status[15:0]}, 32'd0);
        repeat (40) tick();
        check("rstmid_no_pulses", rises - r0, 0);
        check("rstmid_no_done", done_pulses - d0, 0);

        // Lock never settles after the last step
        accept(16'd1, 1'b1, 5'd4, en_first);
        pll_locked = 1'b0;
        wait_done(lat);
        check("lockto_latency", lat, 4101);
        tick();
        check("lockto_err", {30'd0, status[31:30]}, 32'd3);
        check("lockto_position", {16'd0, status[15:0]}, 32'h0001);
        pll_locked = 1'b1;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
